// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, T-state encoding and the
// datapath control word driven by the microcode sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } opcode_t;

    typedef logic [2:0] step_t;

    localparam step_t T0 = 3'd0;
    localparam step_t T1 = 3'd1;
    localparam step_t T2 = 3'd2;
    localparam step_t T3 = 3'd3;
    localparam step_t T4 = 3'd4;

    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic eo;
        logic su;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
        logic fi;
    } ctrl_word_t;

    localparam ctrl_word_t FETCH0    = '{co: 1'b1, mi: 1'b1, default: 1'b0};
    localparam ctrl_word_t FETCH1    = '{ro: 1'b1, ii: 1'b1, ce: 1'b1, default: 1'b0};
    localparam ctrl_word_t HALT_WORD = '{hlt: 1'b1, default: 1'b0};

    // Opcodes that continue past the shared fetch; everything else ends at T1.
    function automatic logic has_execute(input logic [3:0] op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                          OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT};
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> control word and the
// last-step marker that returns the sequencer to T0.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  logic [2:0]  i_step,
    input  logic        i_carry,
    input  logic        i_zero,
    output ctrl_word_t  o_ctrl,
    output logic        o_last
);

    always_comb begin
        o_ctrl = '0;
        o_last = 1'b0;
        case (i_step)
            T0: o_ctrl = FETCH0;
            T1: begin
                o_ctrl = FETCH1;
                o_last = !has_execute(i_opcode);
            end
            T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_ctrl.io = 1'b1;
                        o_ctrl.mi = 1'b1;
                    end
                    OP_LDI: begin
                        o_ctrl.io = 1'b1;
                        o_ctrl.ai = 1'b1;
                        o_last    = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl.io = 1'b1;
                        o_ctrl.j  = 1'b1;
                        o_last    = 1'b1;
                    end
                    OP_JC: begin
                        o_ctrl.io = 1'b1;
                        o_ctrl.j  = i_carry;
                        o_last    = 1'b1;
                    end
                    OP_JZ: begin
                        o_ctrl.io = 1'b1;
                        o_ctrl.j  = i_zero;
                        o_last    = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl.ao = 1'b1;
                        o_ctrl.oi = 1'b1;
                        o_last    = 1'b1;
                    end
                    // No last bit: the top freezes the counter on hlt instead.
                    OP_HLT: o_ctrl.hlt = 1'b1;
                    default: o_last = 1'b1;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.ro = 1'b1;
                        o_ctrl.ai = 1'b1;
                        o_last    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.ro = 1'b1;
                        o_ctrl.bi = 1'b1;
                    end
                    OP_STA: begin
                        o_ctrl.ao = 1'b1;
                        o_ctrl.ri = 1'b1;
                        o_last    = 1'b1;
                    end
                    default: o_last = 1'b1;
                endcase
            end
            T4: begin
                o_last = 1'b1;
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl.eo = 1'b1;
                    o_ctrl.ai = 1'b1;
                    o_ctrl.fi = 1'b1;
                    o_ctrl.su = (i_opcode == OP_SUB);
                end
            end
            default: o_last = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microcode sequencer top: T-state counter, halted flag and reset gating
// around the combinational microcode ROM.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output logic [2:0] step,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi
);

    step_t      r_step;
    logic       r_halted;
    ctrl_word_t w_rom_ctrl;
    logic       w_last;
    ctrl_word_t w_ctrl;

    microcode_rom u_rom (
        .i_opcode (opcode),
        .i_step   (r_step),
        .i_carry  (carry),
        .i_zero   (zero),
        .o_ctrl   (w_rom_ctrl),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_step   <= r_step;
        end else if (w_rom_ctrl.hlt) begin
            // Counter stays at T2 for the whole halt.
            r_halted <= 1'b1;
        end else if (w_last) begin
            r_step   <= T0;
        end else begin
            r_step   <= r_step + 3'd1;
        end
    end

    always_comb begin
        w_ctrl = w_rom_ctrl;
        if (rst) begin
            w_ctrl = '0;
        end else if (r_halted) begin
            w_ctrl = HALT_WORD;
        end
    end

    assign step = r_step;
    assign hlt  = w_ctrl.hlt;
    assign mi   = w_ctrl.mi;
    assign ri   = w_ctrl.ri;
    assign ro   = w_ctrl.ro;
    assign io   = w_ctrl.io;
    assign ii   = w_ctrl.ii;
    assign ai   = w_ctrl.ai;
    assign ao   = w_ctrl.ao;
    assign eo   = w_ctrl.eo;
    assign su   = w_ctrl.su;
    assign bi   = w_ctrl.bi;
    assign oi   = w_ctrl.oi;
    assign ce   = w_ctrl.ce;
    assign co   = w_ctrl.co;
    assign j    = w_ctrl.j;
    assign fi   = w_ctrl.fi;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver pushes the expected
// {step, control lines} for every cycle it drives, a monitor pops and compares.
module tb_control_unit;

    localparam int W = 19;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       carry;
    logic       zero;
    logic [2:0] step;
    logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;

    logic [W-1:0] exp_q[$];
    int           total;
    int           bad;
    int           vec_idx;

    control_unit dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .carry  (carry),
        .zero   (zero),
        .step   (step),
        .hlt    (hlt),
        .mi     (mi),
        .ri     (ri),
        .ro     (ro),
        .io     (io),
        .ii     (ii),
        .ai     (ai),
        .ao     (ao),
        .eo     (eo),
        .su     (su),
        .bi     (bi),
        .oi     (oi),
        .ce     (ce),
        .co     (co),
        .j      (j),
        .fi     (fi)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor / scoreboard: one expected word per driven cycle
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        act = {step, hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL vec%0d: got step=%0d ctrl=%04h, want step=%0d ctrl=%04h",
                         vec_idx, act[18:16], act[15:0], exp_v[18:16], exp_v[15:0]);
            end
            total++;
            if ($isunknown(step) || step > 3'd4) begin
                bad++;
                $display("FAIL step_range vec%0d: got step=%0d, want 0..4", vec_idx, step);
            end
            vec_idx++;
        end
    end

    // Driver: set inputs for one cycle, record what the DUT must show
    task automatic drive(input logic r, input logic [3:0] op, input logic c, input logic z,
                         input logic [2:0] exp_step, input logic [15:0] exp_ctrl);
        rst    = r;
        opcode = op;
        carry  = c;
        zero   = z;
        exp_q.push_back({exp_step, exp_ctrl});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op, input logic c, input logic z);
        drive(1'b0, op, c, z, 3'd0, C_CO | C_MI);
        drive(1'b0, op, c, z, 3'd1, C_RO | C_II | C_CE);
    endtask

    initial begin
        int waited;
        total   = 0;
        bad     = 0;
        vec_idx = 0;
        rst     = 1'b1;
        opcode  = 4'd0;
        carry   = 1'b0;
        zero    = 1'b0;

        // Reset held for three edges; the first cycle has no defined step yet
        @(posedge clk);
        #1;
        drive(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 16'h0000);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // NOP: 2 cycles; opcode is ignored during fetch
        fetch(4'd0, 1'b0, 1'b0);

        // ADD then SUB
        fetch(4'd2, 1'b0, 1'b0);
        drive(1'b0, 4'd2, 1'b0, 1'b0, 3'd2, C_IO | C_MI);
        drive(1'b0, 4'd2, 1'b0, 1'b0, 3'd3, C_RO | C_BI);
        drive(1'b0, 4'd2, 1'b0, 1'b0, 3'd4, C_EO | C_AI | C_FI);
        fetch(4'd3, 1'b1, 1'b1);
        drive(1'b0, 4'd3, 1'b1, 1'b1, 3'd2, C_IO | C_MI);
        drive(1'b0, 4'd3, 1'b1, 1'b1, 3'd3, C_RO | C_BI);
        drive(1'b0, 4'd3, 1'b1, 1'b1, 3'd4, C_EO | C_AI | C_FI | C_SU);

        // JC taken / not taken, JZ taken / not taken (flags crossed to catch swaps)
        fetch(4'd7, 1'b1, 1'b0);
        drive(1'b0, 4'd7, 1'b1, 1'b0, 3'd2, C_IO | C_J);
        fetch(4'd7, 1'b0, 1'b1);
        drive(1'b0, 4'd7, 1'b0, 1'b1, 3'd2, C_IO);
        fetch(4'd8, 1'b0, 1'b1);
        drive(1'b0, 4'd8, 1'b0, 1'b1, 3'd2, C_IO | C_J);
        fetch(4'd8, 1'b1, 1'b0);
        drive(1'b0, 4'd8, 1'b1, 1'b0, 3'd2, C_IO);

        // LDI (3 cycles), undefined 11 (2), JMP, OUT, LDA
        fetch(4'd5, 1'b0, 1'b0);
        drive(1'b0, 4'd5, 1'b0, 1'b0, 3'd2, C_IO | C_AI);
        fetch(4'd11, 1'b0, 1'b0);
        fetch(4'd13, 1'b1, 1'b1);
        fetch(4'd6, 1'b0, 1'b0);
        drive(1'b0, 4'd6, 1'b0, 1'b0, 3'd2, C_IO | C_J);
        fetch(4'd14, 1'b0, 1'b0);
        drive(1'b0, 4'd14, 1'b0, 1'b0, 3'd2, C_AO | C_OI);
        fetch(4'd1, 1'b0, 1'b0);
        drive(1'b0, 4'd1, 1'b0, 1'b0, 3'd2, C_IO | C_MI);
        drive(1'b0, 4'd1, 1'b0, 1'b0, 3'd3, C_RO | C_AI);

        // STA full, then STA aborted by reset in T3
        fetch(4'd4, 1'b0, 1'b0);
        drive(1'b0, 4'd4, 1'b0, 1'b0, 3'd2, C_IO | C_MI);
        drive(1'b0, 4'd4, 1'b0, 1'b0, 3'd3, C_AO | C_RI);
        fetch(4'd4, 1'b0, 1'b0);
        drive(1'b0, 4'd4, 1'b0, 1'b0, 3'd2, C_IO | C_MI);
        drive(1'b1, 4'd4, 1'b0, 1'b0, 3'd3, 16'h0000);
        fetch(4'd0, 1'b0, 1'b0);

        // HLT: T2 plus 20 halted cycles, opcode wiggled to show it is ignored
        fetch(4'd15, 1'b0, 1'b0);
        drive(1'b0, 4'd15, 1'b0, 1'b0, 3'd2, C_HLT);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'd2, C_HLT);
        end
        drive(1'b1, 4'd15, 1'b0, 1'b0, 3'd2, 16'h0000);
        fetch(4'd0, 1'b0, 1'b0);

        // HLT T2 coinciding with reset: reset wins, no halt afterwards
        fetch(4'd15, 1'b0, 1'b0);
        drive(1'b1, 4'd15, 1'b0, 1'b0, 3'd2, 16'h0000);
        fetch(4'd5, 1'b0, 1'b0);
        drive(1'b0, 4'd5, 1'b0, 1'b0, 3'd2, C_IO | C_AI);
        drive(1'b0, 4'd5, 1'b0, 1'b0, 3'd0, C_CO | C_MI);

        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcode sequencer for the 8-bit CPU. It steps through the fetch/execute microsteps (T-states) of the current instruction and drives every control line on the datapath: memory address and RAM, instruction register, A/B registers, the ALU (`eo`, `su`, `fi`), program counter and output register. It decodes the instruction register's opcode nibble, and it resolves conditional jumps from the ALU's registered carry/zero flags.

## Interface
Parameters:
- None. Widths are fixed by the ISA: 4-bit opcode, 3-bit step counter.

Ports (all control outputs are active-high, one cycle per microstep):
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 4: instruction register bits [7:4].
- `carry` input 1: registered ALU carry flag.
- `zero` input 1: registered ALU zero flag.
- `step` output 3: current T-state, 0..4, for debug/display.
- `hlt` output 1: clock halt.
- `mi` output 1: memory address register in.
- `ri` output 1: RAM in.
- `ro` output 1: RAM out.
- `io` output 1: instruction register operand (low nibble) out.
- `ii` output 1: instruction register in.
- `ai` output 1: A register in.
- `ao` output 1: A register out.
- `eo` output 1: ALU result out.
- `su` output 1: ALU subtract.
- `bi` output 1: B register in.
- `oi` output 1: output register in.
- `ce` output 1: PC count enable.
- `co` output 1: PC out.
- `j` output 1: PC load (jump).
- `fi` output 1: ALU flags in.

## Operation
- The step counter starts at T0 and advances by one per clock. Each microcode word carries a `last` bit; when `last` is set, the next step is T0. This gives early termination and variable instruction length (2–5 cycles).
- Every instruction shares the same fetch steps:
  - T0: `co mi`.
  - T1: `ro ii ce`.
  - The opcode is ignored in T0/T1, because the IR is not yet valid.
- Execute steps by opcode:
  - 0 NOP: T1 is last (2 cycles).
  - 1 LDA: T2 `io mi`; T3 `ro ai`, last.
  - 2 ADD: T2 `io mi`; T3 `ro bi`; T4 `eo ai fi`, last.
  - 3 SUB: same as ADD, plus `su` in T4.
  - 4 STA: T2 `io mi`; T3 `ao ri`, last.
  - 5 LDI: T2 `io ai`, last.
  - 6 JMP: T2 `io j`, last.
  - 7 JC: T2 `io`, plus `j` only if `carry`=1; last either way.
  - 8 JZ: as JC, conditioned on `zero`.
  - 14 OUT: T2 `ao oi`, last.
  - 15 HLT: T2 `hlt`, which sets the halted state.
  - 9–13 (undefined): behave as NOP, with T1 last.
- Halted state:
  - `step` freezes at 2.
  - `hlt`=1; all other outputs are 0.
  - Only `rst` exits.
- `su` is asserted only in SUB T4. It is never left asserted for other ALU reads.

## Timing
- Control outputs are combinational from (`step`, `opcode`, `carry`, `zero`, halted state). They are stable for the full cycle and are consumed by the datapath at the next rising edge.
- `carry` and `zero` are sampled combinationally during T2 of JC/JZ. They reflect the last ADD/SUB whose T4 asserted `fi`; flags update on that T4 edge.
- Reset:
  - Applying reset: on a rising edge with `rst`=1, `step`=0 and halted is cleared.
  - Effect on outputs: while `rst`=1 all control outputs are forced to 0, including `hlt`.
  - Release: the first cycle after release is T0 (`co mi`).
- Reset mid-instruction aborts the instruction at that edge; no partial-step completion.
- Simultaneous HLT T2 and `rst`: reset wins, so halted stays 0.
- The counter never exceeds 4. A `last` bit is guaranteed on or before T4; reaching T4 without `last` is impossible by ROM construction (assertion in bench).

## Structure
- Shared package `cpu_pkg`:
  - `opcode_t` enum (NOP…HLT, values above).
  - `step_t` (T0–T4).
  - `ctrl_word_t` packed struct of the 16 control bits.
  - Constants `FETCH0`/`FETCH1` control words.
- Sub-module `microcode_rom`: purely combinational. Maps (opcode, step, carry, zero) to `ctrl_word_t` plus `last`.
- Top level holds only the step counter, the halted flag and reset gating.

## Test plan
- Reset: hold `rst` for 3 cycles. Expect all outputs 0 and `step`=0. After release, expect cycle 1 `co mi`, then cycle 2 `ro ii ce`.
- ADD: `opcode`=2 from T2. Expect T2 `io mi`, T3 `ro bi`, T4 `eo ai fi` with `su`=0, then T0 next cycle. Repeat with SUB (`opcode`=3): identical, plus `su`=1 in T4 only.
- JC: `opcode`=7 with `carry`=1, then with `carry`=0. Expect `io j` at T2 when taken; `io` only, `j`=0, when not taken; the next cycle is T0 in both cases. Repeat for JZ with `zero`.
- Lengths: LDI=3, NOP=2, opcode 11=2 cycles. Check `step` sequences 0,1,2,0 / 0,1,0 / 0,1,0.
- HLT: `opcode`=15. Expect `hlt`=1 from T2 onward for 20 cycles, `step` stuck at 2, all else 0. Assert `rst` for 1 cycle; the next cycle is T0 with `hlt`=0.
- Abort: assert `rst` during STA T3 (`ao ri`). Expect outputs 0 during reset; after release, a fresh fetch with no `ri` pulse.
